// File: rtl/led_scan_trigger_gen.sv
// LED-array scan trigger generator: line sync, blank/toggle/load strobes, column pattern, frame markers.
// Define LED_SCAN_BOUNCE_EN to make mode 3 a bouncing single-bit walk instead of a rotate.
module led_scan_trigger_gen #(
  parameter int COLS       = 28,
  parameter int ROWS       = 32,
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 1023,
  parameter int T_BLANK    = 1,
  parameter int T_TOGGLE   = 6,
  parameter int T_LOAD     = 14
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ena,
  input  logic            i_ext_sync,
  input  logic            i_prm_we,
  input  logic [31:0]     i_prm,
  output logic [COLS-1:0] o_col_pattern,
  output logic            o_toggle_sync,
  output logic            o_head_flag,
  output logic            o_frame_done
);

  localparam int SEQ_W = $clog2(T_LOAD + 2);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [SEQ_W-1:0] SEQ_IDLE   = SEQ_W'(T_LOAD + 1);
  localparam logic [SEQ_W-1:0] SEQ_BLANK  = SEQ_W'(T_BLANK);
  localparam logic [SEQ_W-1:0] SEQ_TOGGLE = SEQ_W'(T_TOGGLE);
  localparam logic [SEQ_W-1:0] SEQ_LOAD   = SEQ_W'(T_LOAD);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] PER_MIN    = CNT_W'(MIN_PERIOD);

  localparam logic [1:0] MODE_FILL   = 2'd0;
  localparam logic [1:0] MODE_WALK   = 2'd1;
  localparam logic [1:0] MODE_HOLE   = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  logic [1:0]       mode;
  logic             free_run;
  logic             active;
  logic [CNT_W-1:0] period;
  logic             prm_upd;

  logic             ena_q;
  logic             ext_q;
  logic [CNT_W-1:0] div;
  logic [SEQ_W-1:0] seq;
  logic [ROW_W-1:0] row;
  logic [COLS-1:0]  pat;
  logic [COLS-1:0]  pat_init;
  logic [COLS-1:0]  pat_step;
  logic [COLS-1:0]  pat_rot;

  logic             start;
  logic             tick;
  logic             sync;
  logic             sync_last;
  logic [CNT_W-1:0] prm_per;

  generate
    if (CNT_W < 28) begin : g_unused
      logic unused_prm_bits;
      assign unused_prm_bits = ^i_prm[27:CNT_W];
    end
  endgenerate

  assign prm_per = i_prm[CNT_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode     <= MODE_FILL;
      free_run <= 1'b0;
      active   <= 1'b0;
      period   <= PER_MIN;
      prm_upd  <= 1'b0;
    end else begin
      prm_upd <= i_prm_we;
      if (i_prm_we) begin
        mode     <= i_prm[31:30];
        free_run <= i_prm[29];
        active   <= i_prm[28];
        period   <= (prm_per < PER_MIN) ? PER_MIN : prm_per;
      end
    end
  end

  assign start     = i_ena & ~ena_q;
  assign tick      = free_run ? (div == period) : (i_ext_sync & ~ext_q);
  assign sync      = start | (ena_q & tick);
  assign sync_last = sync & (row == ROW_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ena_q <= 1'b1;
      ext_q <= 1'b0;
    end else begin
      ena_q <= i_ena;
      ext_q <= i_ext_sync;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div <= '0;
    end else if (prm_upd || !free_run || !ena_q || sync) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seq <= SEQ_IDLE;
    end else if (sync) begin
      seq <= '0;
    end else if (seq != SEQ_IDLE) begin
      seq <= seq + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row <= ROW_LAST;
    end else if (sync) begin
      row <= (row == ROW_LAST) ? '0 : row + 1'b1;
    end
  end

  always_comb begin
    pat_init = '0;
    unique case (mode)
      MODE_FILL: pat_init = '1;
      MODE_HOLE: begin
        pat_init = '1;
        pat_init[COLS-1] = 1'b0;
      end
      default: pat_init[COLS-1] = 1'b1;
    endcase
  end

  assign pat_rot = {pat[COLS-2:0], pat[COLS-1]};

`ifdef LED_SCAN_BOUNCE_EN
  logic dir_down;
  logic dir_nxt;

  // Reverse at either end instead of wrapping the walking bit around.
  always_comb begin
    dir_nxt  = dir_down;
    pat_step = pat;
    unique case (mode)
      MODE_FILL: pat_step = pat;
      MODE_BOUNCE: begin
        if (dir_down) begin
          if (pat[0]) begin
            dir_nxt  = 1'b0;
            pat_step = pat << 1;
          end else begin
            pat_step = pat >> 1;
          end
        end else begin
          if (pat[COLS-1]) begin
            dir_nxt  = 1'b1;
            pat_step = pat >> 1;
          end else begin
            pat_step = pat << 1;
          end
        end
      end
      default: pat_step = pat_rot;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dir_down <= 1'b1;
    end else if (prm_upd) begin
      dir_down <= 1'b1;
    end else if (sync_last) begin
      dir_down <= dir_nxt;
    end
  end
`else
  always_comb begin
    pat_step = pat;
    unique case (mode)
      MODE_FILL: pat_step = pat;
      default:   pat_step = pat_rot;
    endcase
  end
`endif

  // A parameter update takes priority over the end-of-frame step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pat <= '0;
    end else if (prm_upd) begin
      pat <= pat_init;
    end else if (sync_last) begin
      pat <= pat_step;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_col_pattern <= '0;
      o_toggle_sync <= 1'b0;
      o_head_flag   <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      o_frame_done <= sync_last;
      if (seq == SEQ_BLANK) begin
        o_col_pattern <= '0;
        o_head_flag   <= (row == '0);
      end
      if (seq == SEQ_TOGGLE) begin
        o_toggle_sync <= ~o_toggle_sync;
      end
      if (seq == SEQ_LOAD) begin
        o_col_pattern <= active ? pat : '0;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_trigger_gen.sv
// Scoreboard bench for led_scan_trigger_gen: one expected entry per scan line.
// Each toggle edge is a line event; pattern is sampled once the load step is done.
module tb_led_scan_trigger_gen;

  localparam int COLS = 28;
  localparam int ROWS = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b0;
  logic            ext_sync = 1'b0;
  logic            prm_we = 1'b0;
  logic [31:0]     prm = '0;
  logic [COLS-1:0] col_pattern;
  logic            toggle_sync;
  logic            head_flag;
  logic            frame_done;

  always #5 clk = ~clk;

  led_scan_trigger_gen #(
    .COLS(COLS),
    .ROWS(ROWS),
    .CNT_W(24),
    .MIN_PERIOD(1023),
    .T_BLANK(1),
    .T_TOGGLE(6),
    .T_LOAD(14)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_ena(ena),
    .i_ext_sync(ext_sync),
    .i_prm_we(prm_we),
    .i_prm(prm),
    .o_col_pattern(col_pattern),
    .o_toggle_sync(toggle_sync),
    .o_head_flag(head_flag),
    .o_frame_done(frame_done)
  );

  typedef struct {
    int              ivl;
    logic            head;
    logic [COLS-1:0] pat;
    int              fd;
  } line_t;

  line_t exp_q[$];
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int fd_cnt = 0;

  localparam logic [COLS-1:0] MSB = 28'h8000000;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && frame_done) fd_cnt = fd_cnt + 1;
  end

  function automatic logic [31:0] mk(input logic [1:0] m, input logic fr,
                                     input logic act, input int per);
    return {m, fr, act, 4'b0000, 24'(per)};
  endfunction

  task automatic push(input int ivl, input logic head,
                      input logic [COLS-1:0] pat, input int fd);
    line_t e;
    e.ivl = ivl;
    e.head = head;
    e.pat = pat;
    e.fd = fd;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic write_prm(input logic [31:0] v);
    @(negedge clk);
    prm = v;
    prm_we = 1'b1;
    @(negedge clk);
    prm_we = 1'b0;
  endtask

  task automatic ext_pulse();
    @(negedge clk);
    ext_sync = 1'b1;
    @(negedge clk);
    ext_sync = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  // Monitor: pops one expectation per observed line.
  initial begin : mon
    logic  prev;
    int    last_cyc;
    int    last_fd;
    int    n;
    int    ivl;
    int    fd;
    logic  hd;
    line_t e;
    prev = 1'b0;
    last_cyc = 0;
    last_fd = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        continue;
      end
      if (toggle_sync !== prev) begin
        prev = toggle_sync;
        ivl = cyc - last_cyc;
        last_cyc = cyc;
        hd = head_flag;
        fd = fd_cnt - last_fd;
        last_fd = fd_cnt;
        repeat (8) @(negedge clk);
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL line%0d: unexpected line event, pat=%h", n, col_pattern);
        end else begin
          e = exp_q.pop_front();
          if ((e.ivl < 0 || e.ivl == ivl) && hd === e.head &&
              col_pattern === e.pat && fd == e.fd) begin
            passed++;
          end else begin
            $display("FAIL line%0d: got ivl=%0d head=%0b pat=%h frames=%0d, expected ivl=%0d head=%0b pat=%h frames=%0d",
                     n, ivl, hd, col_pattern, fd, e.ivl, e.head, e.pat, e.fd);
          end
        end
        n++;
      end
    end
  end

  initial begin : stim
    logic [COLS-1:0] p;
    int row;
    int k;
    int pos;

    repeat (3) @(negedge clk);
    chk("rst_col", 64'(col_pattern), 64'd0);
    chk("rst_toggle", 64'(toggle_sync), 64'd0);
    chk("rst_head", 64'(head_flag), 64'd0);
    chk("rst_frame", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Free-run, period 1023, mode 1: start line is a last-row sync.
    write_prm(mk(2'd1, 1'b1, 1'b1, 1023));
    repeat (3) @(negedge clk);
    push(-1, 1'b1, 28'h0000001, 1);
    for (int i = 0; i < 4; i++) push(1024, 1'b0, 28'h0000001, 0);
    push(1024, 1'b1, 28'h0000002, 1);
    ena = 1'b1;
    repeat (5 * 1024 + 500) @(negedge clk);

    // Too-small period is clamped; pattern re-initialised mid-frame.
    push(-1, 1'b0, MSB, 0);
    push(1024, 1'b0, MSB, 0);
    write_prm(mk(2'd1, 1'b1, 1'b1, 5));
    repeat (2 * 1024 + 200) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);

    // External sync, inactive output.
    write_prm(mk(2'd1, 1'b0, 1'b0, 1023));
    repeat (3) @(negedge clk);
    push(-1, 1'b0, '0, 0);
    push(-1, 1'b0, '0, 0);
    push(-1, 1'b1, '0, 1);
    push(-1, 1'b0, '0, 0);
    push(-1, 1'b0, '0, 0);
    ena = 1'b1;
    repeat (24) @(negedge clk);
    repeat (3) ext_pulse();
    ext_sync = 1'b1;
    repeat (50) @(negedge clk);
    ext_sync = 1'b0;
    repeat (24) @(negedge clk);

    // Active again, mode 1 walk over ext syncs.
    write_prm(mk(2'd1, 1'b0, 1'b1, 1023));
    repeat (3) @(negedge clk);
    push(-1, 1'b0, MSB, 0);
    push(-1, 1'b0, MSB, 0);
    push(-1, 1'b1, 28'h0000001, 1);
    for (int i = 0; i < 4; i++) push(-1, 1'b0, 28'h0000001, 0);
    repeat (7) ext_pulse();

    // Param update lands on the last-row sync: init wins over step.
    push(-1, 1'b1, 28'h7FFFFFF, 1);
    for (int i = 0; i < 4; i++) push(-1, 1'b0, 28'h7FFFFFF, 0);
    push(-1, 1'b1, 28'hFFFFFFE, 1);
    @(negedge clk);
    prm = mk(2'd2, 1'b0, 1'b1, 1023);
    prm_we = 1'b1;
    @(negedge clk);
    prm_we = 1'b0;
    ext_sync = 1'b1;
    @(negedge clk);
    ext_sync = 1'b0;
    repeat (22) @(negedge clk);
    repeat (5) ext_pulse();

    // Mode 3 across 29 frames.
    write_prm(mk(2'd3, 1'b0, 1'b1, 1023));
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 29 * ROWS; i++) begin
      row = i % ROWS;
      k = i / ROWS;
`ifdef LED_SCAN_BOUNCE_EN
      pos = (k <= COLS - 1) ? (COLS - 1 - k) : (k - (COLS - 1));
`else
      pos = (COLS - 1 + k) % COLS;
`endif
      p = '0;
      p[pos] = 1'b1;
      push(-1, row == 0, p, (row == 0) ? 1 : 0);
      ext_pulse();
    end

    // Reset mid-line, before the toggle step.
    @(negedge clk);
    ext_sync = 1'b1;
    @(negedge clk);
    ext_sync = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_col", 64'(col_pattern), 64'd0);
    chk("midrst_toggle", 64'(toggle_sync), 64'd0);
    chk("midrst_head", 64'(head_flag), 64'd0);
    chk("midrst_frame", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_toggle", 64'(toggle_sync), 64'd0);
    chk("post_col", 64'(col_pattern), 64'd0);
    chk("pending", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
